// File: rtl/top_entity.sv
// top_entity: two-level controller. A low-level stage counter (0..3) divides
// time into HLC cycles; at each HLC tick the latest input event and the
// schedule for streams b, c and d are latched, and the streams are then
// evaluated one per low-level stage so all results are valid in stage 3.
module top_entity (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [63:0] input_a,
  input  logic               new_input,
  output logic               hlc_clock,
  output logic signed [63:0] hlc_a,
  output logic               hlc_enB,
  output logic               hlc_enC,
  output logic               hlc_enD,
  output logic signed [63:0] llc_stage,
  output logic signed [63:0] output_b,
  output logic               output_b_aktv,
  output logic signed [63:0] output_c,
  output logic               output_c_aktv,
  output logic signed [63:0] output_d,
  output logic               output_d_aktv
);

  logic [1:0]         stage_reg;
  logic [63:0]        hc_reg;
  logic               pend_flag_reg;
  logic signed [63:0] pend_val_reg;
  logic               tick;

  // The tick is the enabled edge that leaves stage 3 and closes an HLC cycle.
  assign tick      = en && (stage_reg == 2'd3);
  assign llc_stage = {62'd0, stage_reg};

  // Stage counter, HLC counter and the values latched at each tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_reg <= 2'd0;
      hc_reg    <= 64'd0;
      hlc_clock <= 1'b0;
      hlc_a     <= 64'sd0;
      hlc_enB   <= 1'b0;
      hlc_enC   <= 1'b0;
      hlc_enD   <= 1'b0;
    end else begin
      hlc_clock <= tick;
      if (en) begin
        stage_reg <= stage_reg + 2'd1;
      end
      if (tick) begin
        // hlc_a keeps its old value when no event arrived in the closing cycle.
        if (pend_flag_reg) begin
          hlc_a <= pend_val_reg;
        end
        hlc_enB <= pend_flag_reg;
        hlc_enC <= hc_reg[0];
        hlc_enD <= (hc_reg[1:0] == 2'b11);
        hc_reg  <= hc_reg + 64'd1;
      end
    end
  end

  // Pending event capture: last event in a cycle wins; an event on the tick
  // edge itself seeds the next cycle instead of being dropped by the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_flag_reg <= 1'b0;
      pend_val_reg  <= 64'sd0;
    end else if (en) begin
      if (tick) begin
        pend_flag_reg <= new_input;
      end else if (new_input) begin
        pend_flag_reg <= 1'b1;
      end
      if (new_input) begin
        pend_val_reg <= input_a;
      end
    end
  end

  // Stream evaluation, one stream per stage; unscheduled streams hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      output_b      <= 64'sd0;
      output_b_aktv <= 1'b0;
      output_c      <= 64'sd0;
      output_c_aktv <= 1'b0;
      output_d      <= 64'sd0;
      output_d_aktv <= 1'b0;
    end else if (en) begin
      case (stage_reg)
        2'd0: begin
          if (hlc_enB) begin
            output_b      <= hlc_a + 64'sd1;
            output_b_aktv <= 1'b1;
          end
        end
        2'd1: begin
          if (hlc_enC) begin
            output_c      <= output_c + output_b;
            output_c_aktv <= 1'b1;
          end
        end
        2'd2: begin
          if (hlc_enD) begin
            output_d      <= output_d + output_c;
            output_d_aktv <= 1'b1;
          end
        end
        default: begin
          // Leaving stage 3 is the tick: flags drop so the next cycle starts clean.
          output_b_aktv <= 1'b0;
          output_c_aktv <= 1'b0;
          output_d_aktv <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_entity.sv
// Testbench for top_entity: a table of per-clock vectors with hand-computed
// expectations, followed by hand-written multi-cycle sequences.
module tb_top_entity;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [63:0] input_a;
  logic               new_input;
  logic               hlc_clock;
  logic signed [63:0] hlc_a;
  logic               hlc_enB;
  logic               hlc_enC;
  logic               hlc_enD;
  logic signed [63:0] llc_stage;
  logic signed [63:0] output_b;
  logic               output_b_aktv;
  logic signed [63:0] output_c;
  logic               output_c_aktv;
  logic signed [63:0] output_d;
  logic               output_d_aktv;

  int n_vec = 0;
  int n_bad = 0;

  top_entity dut (
    .clk(clk), .rst(rst), .en(en), .input_a(input_a), .new_input(new_input),
    .hlc_clock(hlc_clock), .hlc_a(hlc_a), .hlc_enB(hlc_enB), .hlc_enC(hlc_enC),
    .hlc_enD(hlc_enD), .llc_stage(llc_stage),
    .output_b(output_b), .output_b_aktv(output_b_aktv),
    .output_c(output_c), .output_c_aktv(output_c_aktv),
    .output_d(output_d), .output_d_aktv(output_d_aktv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic               rst;
    logic               en;
    logic               ni;
    logic signed [63:0] a;
    logic signed [63:0] s;
    logic               hclk;
    logic signed [63:0] ha;
    logic               eb;
    logic               ec;
    logic               ed;
    logic signed [63:0] b;
    logic               ba;
    logic signed [63:0] c;
    logic               ca;
    logic signed [63:0] d;
    logic               da;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int r, input int e, input int n, input longint a,
                     input longint s, input int hc, input longint ha,
                     input int eb, input int ec, input int ed,
                     input longint b, input int ba, input longint c, input int ca,
                     input longint d, input int da);
    vec_t v;
    v.rst = (r != 0);  v.en = (e != 0);  v.ni = (n != 0);  v.a = a;
    v.s = s;  v.hclk = (hc != 0);  v.ha = ha;
    v.eb = (eb != 0);  v.ec = (ec != 0);  v.ed = (ed != 0);
    v.b = b;  v.ba = (ba != 0);  v.c = c;  v.ca = (ca != 0);
    v.d = d;  v.da = (da != 0);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; en = 1'b1; new_input = 1'b0; input_a = 64'sd0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int                 pulses;
    int                 first_pulse;
    int                 first_c;
    longint             c_at;
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    logic               ok;

    rst = 1'b0; en = 1'b0; new_input = 1'b0; input_a = 64'sd0;

    // rst en ni a | stage clk hlc_a enB enC enD | b ba c ca d da
    // Reset for three clocks, with en high to show reset priority.
    repeat (3) add(0,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
    // Event a=1 every HLC cycle; later events land on the tick edge.
    add(1,1,1,1, 1,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0, 2,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0, 3,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,1,1, 0,1,1,1,0,0, 0,0,0,0,0,0);   // tick 1 (hc=0)
    add(1,1,0,0, 1,0,1,1,0,0, 2,1,0,0,0,0);
    add(1,1,0,0, 2,0,1,1,0,0, 2,1,0,0,0,0);
    add(1,1,0,0, 3,0,1,1,0,0, 2,1,0,0,0,0);
    add(1,1,1,1, 0,1,1,1,1,0, 2,0,0,0,0,0);   // tick 2 (hc=1)
    add(1,1,0,0, 1,0,1,1,1,0, 2,1,0,0,0,0);
    add(1,1,0,0, 2,0,1,1,1,0, 2,1,2,1,0,0);
    add(1,1,0,0, 3,0,1,1,1,0, 2,1,2,1,0,0);
    add(1,1,1,1, 0,1,1,1,0,0, 2,0,2,0,0,0);   // tick 3 (hc=2)
    add(1,1,0,0, 1,0,1,1,0,0, 2,1,2,0,0,0);
    add(1,1,0,0, 2,0,1,1,0,0, 2,1,2,0,0,0);
    add(1,1,0,0, 3,0,1,1,0,0, 2,1,2,0,0,0);
    add(1,1,0,0, 0,1,1,1,1,1, 2,0,2,0,0,0);   // tick 4 (hc=3)
    add(1,1,0,0, 1,0,1,1,1,1, 2,1,2,0,0,0);
    add(1,1,0,0, 2,0,1,1,1,1, 2,1,4,1,0,0);
    add(1,1,0,0, 3,0,1,1,1,1, 2,1,4,1,4,1);
    add(1,1,0,0, 0,1,1,0,0,0, 2,0,4,0,4,0);   // tick 5, no event: hlc_a holds
    // Two events in one cycle: a=5 then a=7, last wins.
    add(1,1,1,5, 1,0,1,0,0,0, 2,0,4,0,4,0);
    add(1,1,1,7, 2,0,1,0,0,0, 2,0,4,0,4,0);
    add(1,1,0,0, 3,0,1,0,0,0, 2,0,4,0,4,0);
    add(1,1,0,0, 0,1,7,1,1,0, 2,0,4,0,4,0);   // tick 6 (hc=5)
    add(1,1,0,0, 1,0,7,1,1,0, 8,1,4,0,4,0);
    add(1,1,0,0, 2,0,7,1,1,0, 8,1,12,1,4,0);
    add(1,1,0,0, 3,0,7,1,1,0, 8,1,12,1,4,0);
    add(1,1,0,0, 0,1,7,0,0,0, 8,0,12,0,4,0);  // tick 7 (hc=6)
    add(1,1,0,0, 1,0,7,0,0,0, 8,0,12,0,4,0);
    // en=0 for 5 clocks in stage 1; events offered meanwhile are ignored.
    repeat (5) add(1,0,1,99, 1,0,7,0,0,0, 8,0,12,0,4,0);
    add(1,1,0,0, 2,0,7,0,0,0, 8,0,12,0,4,0);
    add(1,1,0,0, 3,0,7,0,0,0, 8,0,12,0,4,0);
    add(1,1,0,0, 0,1,7,0,1,1, 8,0,12,0,4,0);  // tick 8 (hc=7), no pending
    add(1,1,0,0, 1,0,7,0,1,1, 8,0,12,0,4,0);
    add(1,1,0,0, 2,0,7,0,1,1, 8,0,20,1,4,0);
    add(1,1,0,0, 3,0,7,0,1,1, 8,0,20,1,24,1);
    add(1,1,1,9, 0,1,7,0,0,0, 8,0,20,0,24,0); // tick 9 (hc=8), a=9 pending
    // Mid-cycle reset discards the pending event and restarts at stage 0.
    add(0,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0, 1,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0, 2,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0, 3,0,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,0,0, 0,1,0,0,0,0, 0,0,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; new_input = vecs[i].ni; input_a = vecs[i].a;
      @(posedge clk);
      #1;
      ok = (llc_stage == vecs[i].s) && (hlc_clock == vecs[i].hclk) &&
           (hlc_a == vecs[i].ha) && (hlc_enB == vecs[i].eb) &&
           (hlc_enC == vecs[i].ec) && (hlc_enD == vecs[i].ed) &&
           (output_b == vecs[i].b) && (output_b_aktv == vecs[i].ba) &&
           (output_c == vecs[i].c) && (output_c_aktv == vecs[i].ca) &&
           (output_d == vecs[i].d) && (output_d_aktv == vecs[i].da);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%0d clk=%0b ha=%0d en=%0b%0b%0b b=%0d/%0b c=%0d/%0b d=%0d/%0b; expected st=%0d clk=%0b ha=%0d en=%0b%0b%0b b=%0d/%0b c=%0d/%0b d=%0d/%0b",
                 i, llc_stage, hlc_clock, hlc_a, hlc_enB, hlc_enC, hlc_enD,
                 output_b, output_b_aktv, output_c, output_c_aktv, output_d, output_d_aktv,
                 vecs[i].s, vecs[i].hclk, vecs[i].ha, vecs[i].eb, vecs[i].ec, vecs[i].ed,
                 vecs[i].b, vecs[i].ba, vecs[i].c, vecs[i].ca, vecs[i].d, vecs[i].da);
      end else begin
        $display("ok   vec%0d st=%0d clk=%0b b=%0d c=%0d d=%0d", i, llc_stage, hlc_clock,
                 output_b, output_c, output_d);
      end
    end

    // Free run with no input: tick every 4 clocks, c first active after tick 2.
    do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; new_input = 1'b0;
    pulses = 0; first_pulse = -1; first_c = -1; c_at = -1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (hlc_clock) begin
        pulses++;
        if (first_pulse < 0) first_pulse = e;
      end
      if (output_c_aktv && first_c < 0) begin
        first_c = e;
        c_at = output_c;
      end
    end
    chk("idle_tick_count", pulses, 3);
    chk("idle_first_tick_edge", first_pulse, 4);
    chk("idle_first_c_aktv_edge", first_c, 10);
    chk("idle_c_value", c_at, 0);

    // Wrapping add: b = max + 1 becomes the most negative value.
    max_val = 64'sh7FFF_FFFF_FFFF_FFFF;
    min_val = 64'sh8000_0000_0000_0000;
    do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; new_input = 1'b1; input_a = max_val;
    @(posedge clk);
    @(negedge clk);
    new_input = 1'b0; input_a = 64'sd0;
    repeat (4) @(posedge clk);
    #1;
    chk("wrap_hlc_a", hlc_a, max_val);
    chk("wrap_output_b", output_b, min_val);
    chk("wrap_b_aktv", {63'd0, output_b_aktv}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/top_entity.md
TOP_ENTITY -- requirements
Module: top_entity

Interface
REQ-001 The interface SHALL use one clock; reset is synchronous and active-low.
REQ-002 Ports, in order:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- en  in  1  global enable; when 0, all state holds.
- input_a  in  64 signed  value of input stream a.
- new_input  in  1  a new event of stream a is present this cycle.
- hlc_clock  out  1  one-cycle pulse marking a high-level-controller (HLC) tick.
- hlc_a  out  64 signed  value of a latched at the last tick.
- hlc_enB  out  1  b is scheduled in the current HLC cycle.
- hlc_enC  out  1  c is scheduled in the current HLC cycle.
- hlc_enD  out  1  d is scheduled in the current HLC cycle.
- llc_stage  out  64 signed  low-level-controller stage, 0..3.
- output_b  out  64 signed  value of stream b.
- output_b_aktv  out  1  b was evaluated in the current HLC cycle.
- output_c  out  64 signed  value of stream c.
- output_c_aktv  out  1  c was evaluated in the current HLC cycle.
- output_d  out  64 signed  value of stream d.
- output_d_aktv  out  1  d was evaluated in the current HLC cycle.

Function
REQ-003 When en=1, llc_stage SHALL count 0,1,2,3,0,... by one per clock; one HLC cycle is 4 clocks.
REQ-004 Pending event: any edge with en=1 and new_input=1 SHALL set a pending flag and store input_a; a later event in the same HLC cycle SHALL overwrite the stored value (last wins).
REQ-005 Tick edge: the edge with en=1 and llc_stage=3.
REQ-006 On the tick edge, the block SHALL:
- set hlc_clock to 1 (0 on every other edge);
- load hlc_a with the pending value and hlc_enB with the pending flag;
- load hlc_enC with bit 0 of the 64-bit HLC counter hc, and hlc_enD with (hc[1:0]==3);
- increment hc (wrapping);
- clear the pending flag.
REQ-007 If new_input=1 on the tick edge, that event SHALL become the new pending event after the clear (it is not lost).
REQ-008 hlc_a SHALL hold its value when hlc_enB=0.
REQ-009 Stream evaluation SHALL occur only when en=1:
- edge leaving stage 0: if hlc_enB, output_b <= hlc_a + 1 and output_b_aktv <= 1;
- edge leaving stage 1: if hlc_enC, output_c <= output_c + output_b and output_c_aktv <= 1;
- edge leaving stage 2: if hlc_enD, output_d <= output_d + output_c and output_d_aktv <= 1.
REQ-010 Unscheduled streams SHALL hold their value (sample-and-hold).
REQ-011 All *_aktv flags SHALL clear on the tick edge, so results and flags are all valid together during stage 3.
REQ-012 All additions SHALL be 64-bit two's complement and wrap silently on overflow.
REQ-013 Latency: an event sampled in HLC cycle N SHALL appear on output_b one clock after the tick ending cycle N.
REQ-014 en=0 SHALL freeze llc_stage, hc, the pending event, and all outputs, and SHALL force hlc_clock to 0.

Reset
REQ-015 On an edge with rst=0 (priority over en), all of the following SHALL become 0: every output, llc_stage, hc and the pending flag.
REQ-016 Reset asserted mid-HLC cycle SHALL discard the pending event and partial results; counting SHALL restart at stage 0.

Verification
REQ-017 Reset: rst=0 for 3 clocks -> every output reads 0.
REQ-018 rst=1, en=1, no input:
- llc_stage reads 0,1,2,3 repeating;
- hlc_clock pulses once every 4 clocks;
- output_c_aktv first goes high in the 2nd HLC cycle with output_c=0.
REQ-019 input_a=1 with new_input held for 1 clock, then the next tick -> hlc_a=1 and hlc_enB=1; one clock later output_b=2 and output_b_aktv=1; output_b_aktv clears at the following tick.
REQ-020 Events a=5 then a=7 in the same HLC cycle -> exactly one evaluation, with output_b=8.
REQ-021 Event a=1 in every HLC cycle from the first -> at ticks 1..4:
- b=2 each cycle;
- c=2 at the 2nd cycle and c=4 at the 4th;
- d=4 at the 4th cycle.
REQ-022 en=0 for 5 clocks during stage 1 -> llc_stage stays 1, outputs unchanged, no hlc_clock pulse; on resume the sequence continues from stage 1.
